// File: rtl/io_input_cond.sv
// Board input conditioner: synchronizes switches and buttons into i_clk, debounces
// buttons, and emits one-cycle press pulses plus software-clearable sticky press flags.
module io_input_cond #(
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned BTN_ACTIVE_LOW  = 1
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [31:0] i_sw_raw,
  input  logic [3:0]  i_btn_raw,
  input  logic [3:0]  i_btn_clr,
  output logic [31:0] o_io_sw,
  output logic [3:0]  o_io_btn,
  output logic [3:0]  o_btn_press,
  output logic [3:0]  o_btn_sticky
);

  localparam int unsigned SW_W   = 32;
  localparam int unsigned BTN_N  = 4;
  localparam int unsigned CNT_W  = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SW_W-1:0]  r_sw_sync  [SYNC_STAGES];
  logic [BTN_N-1:0] r_btn_sync [SYNC_STAGES];
  logic [CNT_W-1:0] r_cnt      [BTN_N];
  logic [BTN_N-1:0] r_deb;
  logic [BTN_N-1:0] r_press;
  logic [BTN_N-1:0] r_sticky;

  logic [BTN_N-1:0] w_btn_in;
  logic [BTN_N-1:0] w_btn_s;
  logic [BTN_N-1:0] w_flip;
  logic [BTN_N-1:0] w_rise;

  // Polarity normalization so that internal 1 always means pressed
  assign w_btn_in = (BTN_ACTIVE_LOW != 0) ? ~i_btn_raw : i_btn_raw;
  assign w_btn_s  = r_btn_sync[SYNC_STAGES-1];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int k = 0; k < int'(SYNC_STAGES); k++) begin
        r_sw_sync[k]  <= '0;
        r_btn_sync[k] <= '0;
      end
    end else begin
      r_sw_sync[0]  <= i_sw_raw;
      r_btn_sync[0] <= w_btn_in;
      for (int k = 1; k < int'(SYNC_STAGES); k++) begin
        r_sw_sync[k]  <= r_sw_sync[k-1];
        r_btn_sync[k] <= r_btn_sync[k-1];
      end
    end
  end

  // Flip happens on the DEBOUNCE_CYCLES-th consecutive mismatching cycle
  always_comb begin
    w_flip = '0;
    for (int i = 0; i < int'(BTN_N); i++) begin
      w_flip[i] = (w_btn_s[i] != r_deb[i]) && (r_cnt[i] == CNT_MAX);
    end
    w_rise = w_flip & ~r_deb;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < int'(BTN_N); i++) begin
        r_cnt[i] <= '0;
      end
      r_deb    <= '0;
      r_press  <= '0;
      r_sticky <= '0;
    end else begin
      for (int i = 0; i < int'(BTN_N); i++) begin
        if (w_btn_s[i] == r_deb[i]) begin
          r_cnt[i] <= '0;
        end else if (w_flip[i]) begin
          r_deb[i] <= w_btn_s[i];
          r_cnt[i] <= '0;
        end else begin
          r_cnt[i] <= r_cnt[i] + CNT_W'(1);
        end
      end
      r_press  <= w_rise;
      // Press wins over a same-cycle clear
      r_sticky <= w_rise | (r_sticky & ~i_btn_clr);
    end
  end

  assign o_io_sw      = r_sw_sync[SYNC_STAGES-1];
  assign o_io_btn     = r_deb;
  assign o_btn_press  = r_press;
  assign o_btn_sticky = r_sticky;

endmodule

// File: tb/tb_io_input_cond.sv
// Directed bench for io_input_cond: a vector table for the main sequence plus
// hand-written reset-mid-debounce and active-low polarity sequences.
module tb_io_input_cond;

  localparam logic [31:0] SW_A = 32'hA5A5_0F0F;
  localparam logic [31:0] SW_B = 32'h1234_5678;

  logic        clk;
  logic        rst_n;
  logic [31:0] sw_raw;
  logic [3:0]  btn_raw;
  logic [3:0]  btn_clr;
  logic [31:0] io_sw;
  logic [3:0]  io_btn;
  logic [3:0]  btn_press;
  logic [3:0]  btn_sticky;

  logic [31:0] pol_sw_raw;
  logic [3:0]  pol_btn_raw;
  logic [3:0]  pol_btn_clr;
  logic [31:0] pol_io_sw;
  logic [3:0]  pol_io_btn;
  logic [3:0]  pol_press;
  logic [3:0]  pol_sticky;

  int n_vec;
  int n_err;

  typedef struct {
    logic [31:0] sw;
    logic [3:0]  btn;
    logic [3:0]  clr;
    logic [31:0] exp_sw;
    logic [3:0]  exp_btn;
    logic [3:0]  exp_press;
    logic [3:0]  exp_sticky;
  } vec_t;

  vec_t tbl[$];

  io_input_cond #(.SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .BTN_ACTIVE_LOW(0)) u_dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_sw_raw(sw_raw), .i_btn_raw(btn_raw),
    .i_btn_clr(btn_clr), .o_io_sw(io_sw), .o_io_btn(io_btn),
    .o_btn_press(btn_press), .o_btn_sticky(btn_sticky)
  );

  io_input_cond #(.SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .BTN_ACTIVE_LOW(1)) u_pol (
    .i_clk(clk), .i_rst_n(rst_n), .i_sw_raw(pol_sw_raw), .i_btn_raw(pol_btn_raw),
    .i_btn_clr(pol_btn_clr), .o_io_sw(pol_io_sw), .o_io_btn(pol_io_btn),
    .o_btn_press(pol_press), .o_btn_sticky(pol_sticky)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic add(input logic [31:0] sw, input logic [3:0] btn, input logic [3:0] clr,
                     input logic [31:0] esw, input logic [3:0] eb, input logic [3:0] ep,
                     input logic [3:0] es);
    vec_t v;
    v.sw = sw; v.btn = btn; v.clr = clr;
    v.exp_sw = esw; v.exp_btn = eb; v.exp_press = ep; v.exp_sticky = es;
    tbl.push_back(v);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_sw"},     io_sw,              32'h0);
    chk({tag, "_btn"},    32'(io_btn),        32'h0);
    chk({tag, "_press"},  32'(btn_press),     32'h0);
    chk({tag, "_sticky"}, 32'(btn_sticky),    32'h0);
    chk({tag, "_polbtn"}, 32'(pol_io_btn),    32'h0);
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;

    // Edge numbers below count from the first edge after reset release
    add(SW_A, 4'h1, 4'h0, 32'h0, 4'h0, 4'h0, 4'h0);                 // 1
    for (int n = 2; n <= 5; n++) add(SW_A, 4'h1, 4'h0, SW_A, 4'h0, 4'h0, 4'h0);
    add(SW_A, 4'h1, 4'h0, SW_A, 4'h1, 4'h1, 4'h1);                  // 6: clean press
    add(SW_A, 4'h1, 4'h0, SW_A, 4'h1, 4'h0, 4'h1);                  // 7
    for (int n = 8; n <= 12; n++) add(SW_A, 4'h0, 4'h0, SW_A, 4'h1, 4'h0, 4'h1);
    add(SW_A, 4'h0, 4'h0, SW_A, 4'h0, 4'h0, 4'h1);                  // 13: release, no pulse
    for (int n = 14; n <= 16; n++) add(SW_A, 4'h2, 4'h0, SW_A, 4'h0, 4'h0, 4'h1);
    add(SW_A, 4'h0, 4'h0, SW_A, 4'h0, 4'h0, 4'h1);                  // 17: bounce low
    for (int n = 18; n <= 22; n++) add(SW_A, 4'h2, 4'h0, SW_A, 4'h0, 4'h0, 4'h1);
    add(SW_A, 4'h2, 4'h0, SW_A, 4'h2, 4'h2, 4'h3);                  // 23
    add(SW_A, 4'h2, 4'h0, SW_A, 4'h2, 4'h0, 4'h3);                  // 24
    add(SW_B, 4'h6, 4'h0, SW_A, 4'h2, 4'h0, 4'h3);                  // 25
    for (int n = 26; n <= 29; n++) add(SW_B, 4'h6, 4'h0, SW_B, 4'h2, 4'h0, 4'h3);
    add(SW_B, 4'h6, 4'h0, SW_B, 4'h6, 4'h4, 4'h7);                  // 30
    add(SW_B, 4'h6, 4'h4, SW_B, 4'h6, 4'h0, 4'h3);                  // 31: clear btn2
    add(SW_B, 4'h6, 4'h0, SW_B, 4'h6, 4'h0, 4'h3);                  // 32
    for (int n = 33; n <= 37; n++) add(SW_B, 4'hE, 4'h0, SW_B, 4'h6, 4'h0, 4'h3);
    add(SW_B, 4'hE, 4'h9, SW_B, 4'hE, 4'h8, 4'hA);                  // 38: press+clear collide
    add(SW_B, 4'hE, 4'h0, SW_B, 4'hE, 4'h0, 4'hA);                  // 39

    rst_n       = 1'b1;
    sw_raw      = SW_A;
    btn_raw     = 4'h0;
    btn_clr     = 4'h0;
    pol_sw_raw  = 32'h0;
    pol_btn_raw = 4'hF;
    pol_btn_clr = 4'h0;

    // Asynchronous reset asserted mid-cycle
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b0;
    #1 check_all_zero("async_rst");
    @(posedge clk);
    #1 rst_n = 1'b1;

    foreach (tbl[n]) begin
      sw_raw  = tbl[n].sw;
      btn_raw = tbl[n].btn;
      btn_clr = tbl[n].clr;
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_sw", n + 1),     io_sw,             tbl[n].exp_sw);
      chk($sformatf("v%0d_btn", n + 1),    32'(io_btn),       32'(tbl[n].exp_btn));
      chk($sformatf("v%0d_press", n + 1),  32'(btn_press),    32'(tbl[n].exp_press));
      chk($sformatf("v%0d_sticky", n + 1), 32'(btn_sticky),   32'(tbl[n].exp_sticky));
    end

    // Reset mid-debounce with button 0 held throughout
    btn_clr = 4'h0;
    #3 rst_n = 1'b0;
    #1 check_all_zero("rst2");
    @(posedge clk);
    #1 rst_n = 1'b1;
    btn_raw = 4'h1;
    for (int k = 1; k <= 4; k++) begin
      @(posedge clk);
      #1;
      chk($sformatf("pre_e%0d_btn", k), 32'(io_btn), 32'h0);
    end
    #3 rst_n = 1'b0;
    #1 check_all_zero("rst3");
    @(posedge clk);
    #1 rst_n = 1'b1;
    pol_btn_raw = 4'b1110;
    for (int k = 1; k <= 7; k++) begin
      @(posedge clk);
      #1;
      chk($sformatf("post_e%0d_btn", k),    32'(io_btn),     (k >= 6) ? 32'h1 : 32'h0);
      chk($sformatf("post_e%0d_press", k),  32'(btn_press),  (k == 6) ? 32'h1 : 32'h0);
      chk($sformatf("post_e%0d_sticky", k), 32'(btn_sticky), (k >= 6) ? 32'h1 : 32'h0);
      chk($sformatf("pol_e%0d_btn", k),     32'(pol_io_btn), (k >= 6) ? 32'h1 : 32'h0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/io_input_cond.md
# io_input_cond

Input conditioner for the board-level switches and push-buttons. It sits directly upstream of the core's `i_io_sw`/`i_io_btn` inputs and is instantiated at the top level between the FPGA pins and the single-cycle CPU. It synchronizes every raw input into the `i_clk` domain and debounces the buttons. It also produces one-cycle press pulses and sticky press flags, so software polling through the LSU never misses a press.

## Interface
- `SYNC_STAGES`, 2: synchronizer depth for every raw input; legal values are ≥2.
- `DEBOUNCE_CYCLES`, 500000: consecutive cycles a synchronized button must differ from its debounced level before the level flips. Legal values are ≥2; the default is 10 ms at 50 MHz.
- `BTN_ACTIVE_LOW`, 1: when 1, raw buttons are inverted before synchronization, so internal 1 always means pressed.
- `i_clk`  in  1  the single clock, rising-edge active.
- `i_rst_n`  in  1  reset, asynchronous and active-low.
- `i_sw_raw`  in  32  raw switch pins, asynchronous.
- `i_btn_raw`  in  4  raw button pins, asynchronous, polarity set by `BTN_ACTIVE_LOW`.
- `i_btn_clr`  in  4  per-button sticky-flag clear strobe, synchronous to `i_clk`, driven by the LSU write decode.
- `o_io_sw`  out  32  synchronized switch levels; these connect to the core's `i_io_sw`.
- `o_io_btn`  out  4  debounced button levels (1 = pressed); these connect to the core's `i_io_btn`.
- `o_btn_press`  out  4  one-cycle pulse on each debounced 0→1 transition.
- `o_btn_sticky`  out  4  latched press flag, held until cleared.

## Operation
- Switches: each bit passes through a `SYNC_STAGES`-deep flop chain. There is no debounce on switches. `o_io_sw` is the last stage of the chain.
- Buttons: the optional inversion is applied first. Each bit then passes through a `SYNC_STAGES` chain, and the synchronized value `s[i]` feeds a per-button debouncer.
- Debouncer per button: one debounced level `d[i]` (this drives `o_io_btn[i]`) and a counter `cnt[i]` of width $clog2(DEBOUNCE_CYCLES).
  - If `s[i] == d[i]`: `cnt[i]` <= 0.
  - If `s[i] != d[i]` and `cnt[i] < DEBOUNCE_CYCLES-1`: `cnt[i]` <= `cnt[i]`+1.
  - If `s[i] != d[i]` and `cnt[i] == DEBOUNCE_CYCLES-1`: `d[i]` <= `s[i]` and `cnt[i]` <= 0.
  - Any single cycle in which `s[i]` matches `d[i]` restarts the count. Bounces shorter than `DEBOUNCE_CYCLES` synchronized cycles are therefore rejected.
  - The counter never wraps; it saturates via the flip at `DEBOUNCE_CYCLES`-1.
- Press pulse: `o_btn_press[i]` is a register. It is set to 1 on the same edge where `d[i]` goes 0→1, and it is 0 on every other edge. A release (1→0) produces no pulse.
- Sticky flag, updated each edge, with set having priority:
  - If a press event occurs (the same condition that sets the pulse): `o_btn_sticky[i]` <= 1.
  - Else if `i_btn_clr[i]`: `o_btn_sticky[i]` <= 0.
  - Else the flag holds.
  - A clear on the same cycle as a press does not lose the press.
- Buttons are fully independent. Simultaneous presses on several buttons each produce their own pulse and flag.

## Timing
- Reset (`i_rst_n`=0, asynchronous) forces the following, regardless of clock:
  - all synchronizer flops to 0;
  - every `d[i]` to 0 and every `cnt[i]` to 0;
  - `o_io_sw`=0, `o_io_btn`=0, `o_btn_press`=0, `o_btn_sticky`=0.
- Reset release is used synchronously, without an extra release synchronizer (it is inherited from the top-level reset). The first functional edge is the first rising edge with `i_rst_n`=1.
- Reset mid-debounce discards the partial count. A button held through reset must complete a full `DEBOUNCE_CYCLES` count after release before it reads pressed, and that press produces a pulse and sets the sticky flag.
- Switch latency: a raw change that is stable before edge 1 appears on `o_io_sw` after edge `SYNC_STAGES`.
- Button latency: a raw change that is stable from before edge 1 appears on `o_io_btn` and `o_btn_press` after edge `SYNC_STAGES`+`DEBOUNCE_CYCLES`. Release uses the same latency.
- `o_btn_press` is high for exactly one cycle per press. `o_btn_sticky` rises on the same edge as `o_btn_press`.
- `i_btn_clr` takes effect on the next edge; the sticky flag reads 0 in the following cycle.
- All outputs are registered, with no combinational path from any input to any output.

## Test plan
Benches use `SYNC_STAGES`=2, `DEBOUNCE_CYCLES`=4, `BTN_ACTIVE_LOW`=0.
- Reset and switch path: assert `i_rst_n`=0 mid-cycle with `i_sw_raw`=32'hA5A5_0F0F → all outputs 0 immediately. Release reset → `o_io_sw`=32'hA5A5_0F0F after the 2nd edge.
- Clean press: `btn_raw[0]` goes 0→1 before edge 1 and is held → `o_io_btn[0]`=1, `o_btn_press[0]`=1 and `o_btn_sticky[0]`=1 after edge 6. `o_btn_press[0]` returns to 0 after edge 7. Release → `o_io_btn[0]`=0 six edges later, with no pulse.
- Bounce rejection: `btn_raw[1]` high for 3 cycles, then low 1 cycle, then high and held → no output change until 6 edges after the final rise, then exactly one pulse.
- Sticky clear and collision: after a press on button 2, pulse `i_btn_clr[2]` for 1 cycle → `o_btn_sticky[2]`=0 next cycle. Then pulse `i_btn_clr[3]` on the exact edge where button 3's press registers → `o_btn_sticky[3]`=1.
- Reset mid-debounce: hold `btn_raw[0]`=1, assert reset after edge 4 and release it → `o_io_btn[0]` rises exactly 6 edges after release, with one pulse.
- Polarity: rebuild with `BTN_ACTIVE_LOW`=1 and drive `i_btn_raw`=4'b1110 → `o_io_btn`=4'b0001 after 6 edges.
